// File: rtl/prng_lcg_gen.sv
// Linear congruential pseudo-random generator with a one-entry valid/ready output slot.
// The generator runs freely in RUN, or produces single values on step while IDLE.
module prng_lcg_gen #(
    parameter int unsigned WIDTH      = 12,
    parameter logic [31:0] MULT       = 32'd3,
    parameter logic [31:0] INC        = 32'd4,
    parameter logic [31:0] RESET_SEED = 32'd1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [WIDTH-1:0] MULT_W = MULT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] INC_W  = INC[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_W = RESET_SEED[WIDTH-1:0];

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             hs;
    logic             slot_free;

    // Full-precision product, truncated to the generator width.
    function automatic logic [WIDTH-1:0] next_val(input logic [WIDTH-1:0] x);
        logic [2*WIDTH-1:0] prod;
        prod = {{WIDTH{1'b0}}, MULT_W} * {{WIDTH{1'b0}}, x} + {{WIDTH{1'b0}}, INC_W};
        return prod[WIDTH-1:0];
    endfunction

    assign hs        = valid_q & data_ready;
    assign slot_free = ~valid_q | data_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q + {{(CNT_W-1){1'b0}}, hs};
        if (load) begin
            state_d = IDLE;
            data_d  = seed;
            valid_d = 1'b0;
            count_d = '0;
        end else if (stop) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else if (state_q == RUN) begin
            if (slot_free) begin
                data_d  = next_val(data_q);
                valid_d = 1'b1;
            end
        end else if (start) begin
            state_d = RUN;
            if (hs) valid_d = 1'b0;
        end else if (step && slot_free) begin
            data_d  = next_val(data_q);
            valid_d = 1'b1;
        end else if (hs) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            data_q  <= SEED_W;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign busy       = (state_q == RUN);
    assign count      = count_q;

endmodule

// File: tb/tb_prng_lcg_gen.sv
// Bench for prng_lcg_gen: directed scenarios plus random control traffic against a slot model.
module tb_prng_lcg_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, stop = 1'b0, step = 1'b0, load = 1'b0;
    logic [11:0] seed = '0;
    logic        data_ready = 1'b0;
    logic [11:0] data_out, data_out2;
    logic        data_valid, data_valid2, busy, busy2;
    logic [15:0] count;
    logic [3:0]  count2;

    int checks = 0;
    int errors = 0;

    // Reference state: run flag, generator value, slot occupancy, unbounded accept count.
    bit m_run = 0;
    int m_x   = 1;
    bit m_v   = 0;
    int m_cnt = 0;

    prng_lcg_gen dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step), .load(load),
        .seed(seed), .data_out(data_out), .data_valid(data_valid),
        .data_ready(data_ready), .busy(busy), .count(count)
    );

    prng_lcg_gen #(.CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step), .load(load),
        .seed(seed), .data_out(data_out2), .data_valid(data_valid2),
        .data_ready(data_ready), .busy(busy2), .count(count2)
    );

    always #5 clk = ~clk;

    function automatic int f(input int x);
        return (3 * x + 4) % 4096;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the slot is consumed first, then refilled if the mode allows it.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_run = 0; m_x = 1; m_v = 0; m_cnt = 0;
        end else if (load) begin
            m_run = 0; m_x = int'(seed); m_v = 0; m_cnt = 0;
        end else begin
            if (m_v && data_ready) begin
                m_v = 0;
                m_cnt++;
            end
            if (stop) begin
                m_run = 0;
                m_v   = 0;
            end else if (m_run) begin
                if (!m_v) begin m_x = f(m_x); m_v = 1; end
            end else if (start) begin
                m_run = 1;
            end else if (step && !m_v) begin
                m_x = f(m_x);
                m_v = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("data_out", 32'(data_out), 32'(m_x));
        chk("data_valid", 32'(data_valid), 32'(m_v));
        chk("busy", 32'(busy), 32'(m_run));
        chk("count", 32'(count), 32'(m_cnt % 65536));
        chk("count4", 32'(count2), 32'(m_cnt % 16));
        chk("data_out2", 32'(data_out2), 32'(m_x));
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr;
        start = 0; stop = 0; step = 0; load = 0;
    endtask

    task automatic do_load(input int s);
        load = 1; seed = 12'(s);
        tick();
        load = 0;
    endtask

    int exp_seq[6] = '{19, 61, 187, 565, 1699, 1005};

    initial begin
        tick(2);
        chk("reset data_out", 32'(data_out), 32'd1);
        chk("reset valid", 32'(data_valid), 32'd0);
        chk("reset count", 32'(count), 32'd0);
        rst = 1;
        tick();

        // Free run from seed 5 with the consumer always ready.
        do_load(5);
        chk("load data_out", 32'(data_out), 32'd5);
        data_ready = 1; start = 1;
        tick();
        start = 0;
        chk("start busy", 32'(busy), 32'd1);
        chk("start no valid yet", 32'(data_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("run seq", 32'(data_out), 32'(exp_seq[i]));
            chk("run valid", 32'(data_valid), 32'd1);
        end
        tick();
        chk("run count", 32'(count), 32'd6);

        // Backpressure: value frozen while stalled.
        data_ready = 0;
        do_load(5);
        start = 1; tick(); start = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall hold", 32'(data_out), 32'd19);
            chk("stall count", 32'(count), 32'd0);
            tick();
        end
        data_ready = 1;
        tick();
        chk("stall release", 32'(data_out), 32'd61);
        chk("stall count after", 32'(count), 32'd1);

        // load beats stop and start.
        load = 1; stop = 1; start = 1; seed = 12'd100;
        tick();
        clr();
        chk("prio data_out", 32'(data_out), 32'd100);
        chk("prio busy", 32'(busy), 32'd0);
        chk("prio count", 32'(count), 32'd0);
        chk("prio valid", 32'(data_valid), 32'd0);
        start = 1; stop = 1;
        tick();
        clr();
        chk("start+stop idle", 32'(busy), 32'd0);

        // Single step with wrap from 4095.
        data_ready = 0;
        do_load(4095);
        step = 1; tick(); step = 0;
        chk("step wrap", 32'(data_out), 32'd1);
        chk("step valid", 32'(data_valid), 32'd1);
        tick(2);
        chk("step held valid", 32'(data_valid), 32'd1);
        chk("step busy", 32'(busy), 32'd0);
        data_ready = 1;
        tick();
        chk("step consumed", 32'(data_valid), 32'd0);
        chk("step count", 32'(count), 32'd1);

        // Count wrap on the narrow counter, 16 accepts.
        do_load(5);
        start = 1; tick(); start = 0;
        tick(17);
        chk("count16", 32'(count), 32'd16);
        chk("count4 wrap", 32'(count2), 32'd0);

        // Asynchronous reset between edges.
        @(posedge clk);
        #2 rst = 0;
        #1;
        chk("async data_out", 32'(data_out), 32'd1);
        chk("async valid", 32'(data_valid), 32'd0);
        chk("async busy", 32'(busy), 32'd0);
        chk("async count", 32'(count), 32'd0);
        tick();
        #2 rst = 1;
        tick(3);
        chk("post reset idle", 32'(data_out), 32'd1);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            load       = ($urandom_range(0, 99) < 2);
            stop       = ($urandom_range(0, 99) < 5);
            start      = ($urandom_range(0, 99) < 10);
            step       = ($urandom_range(0, 99) < 30);
            data_ready = ($urandom_range(0, 99) < 60);
            seed       = 12'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 0;
                tick();
                #2 rst = 1;
            end
            tick();
        end
        clr();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prng_lcg_gen.md
PRNG_LCG_GEN -- requirements
Module: prng_lcg_gen

Interface
REQ-001 Parameter WIDTH, default 12, generator state and output width in bits (range 4..32).
REQ-002 Parameter MULT, default 3, LCG multiplier; only its low WIDTH bits are used.
REQ-003 Parameter INC, default 4, LCG increment; only its low WIDTH bits are used.
REQ-004 Parameter RESET_SEED, default 1, generator state after reset.
REQ-005 Parameter CNT_W, default 16, width of the accepted-sample counter.
REQ-006 Port clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-007 Port rst  input  1  asynchronous, active-low reset.
REQ-008 Port start  input  1  level; enter free-running mode.
REQ-009 Port stop  input  1  level; leave free-running mode.
REQ-010 Port step  input  1  level; generate exactly one value while idle.
REQ-011 Port load  input  1  level; load seed into the generator.
REQ-012 Port seed  input  WIDTH  seed value, sampled only when load=1.
REQ-013 Port data_out  output  WIDTH  current generator state and output sample.
REQ-014 Port data_valid  output  1  data_out holds a new, not-yet-accepted sample.
REQ-015 Port data_ready  input  1  consumer accepts the sample when data_valid=1 and data_ready=1 at a rising edge.
REQ-016 Port busy  output  1  high while the FSM is in RUN.
REQ-017 Port count  output  CNT_W  number of accepted samples, modulo 2^CNT_W.

Function
REQ-018 The next-value function SHALL be f(x) = (MULT*x + INC) mod 2^WIDTH, computed at full precision and then truncated; the block SHALL NOT guarantee full period.
REQ-019 The FSM SHALL have two states: IDLE and RUN; busy=1 exactly in RUN.
REQ-020 Per-edge control priority SHALL be load > stop > start > step.
REQ-021 load=1 in either state: data_out<=seed, data_valid<=0, count<=0, state<=IDLE; all other inputs ignored that cycle.
REQ-022 stop=1 (no load): state<=IDLE, data_valid<=0, data_out and count retained; a sample pending at that edge SHALL be dropped unless the handshake completes on the same edge, in which case count increments.
REQ-023 start=1 in IDLE (no load/stop): state<=RUN; no generation on that edge.
REQ-024 "Slot free" SHALL mean data_valid=0 or data_ready=1 at the edge.
REQ-025 In RUN with slot free (no load/stop): data_out<=f(data_out), data_valid<=1; one new sample per cycle at full throughput.
REQ-026 In RUN with slot not free: data_out and data_valid SHALL hold (no sample lost, no value skipped).
REQ-027 step=1 in IDLE with slot free (no load/start/stop): data_out<=f(data_out), data_valid<=1, state stays IDLE; step held high SHALL produce one value per free slot.
REQ-028 In IDLE without generation, a completed handshake SHALL clear data_valid.
REQ-029 Every completed handshake SHALL increment count by 1, wrapping from 2^CNT_W-1 to 0.
REQ-030 Latency: start sampled at edge N gives data_valid=1 after edge N+1; step sampled at edge N gives data_valid=1 after edge N.
REQ-031 start and step in RUN SHALL be ignored.

Reset
REQ-032 rst=0 SHALL immediately, without a clock, force state=IDLE, data_out=RESET_SEED[WIDTH-1:0], data_valid=0, busy=0, count=0.
REQ-033 Reset asserted mid-run SHALL discard any pending sample; after release the block SHALL wait in IDLE for start, step or load.
REQ-034 Reset release SHALL take effect on the first rising clk edge after rst=1.

Verification (WIDTH=12, MULT=3, INC=4, CNT_W=16)
REQ-035 Reset, load seed=5, start, data_ready=1 throughout -> data_out sequence 19, 61, 187, 565, 1699, 1005 on consecutive cycles; count=6; first valid 2 cycles after start.
REQ-036 load seed=4095, step once -> data_out=1 (wrap), data_valid=1 until data_ready pulse, busy=0 throughout.
REQ-037 RUN with data_ready=0 for 5 cycles then 1 -> data_out frozen at 19 while stalled, then 61; no value skipped, count increments only on accepted cycles.
REQ-038 start=stop=1 together in IDLE -> stays IDLE; load=stop=start=1 in RUN -> data_out=seed, IDLE, count=0, data_valid=0.
REQ-039 rst pulled low between edges mid-run -> outputs reach their reset values before the next edge; data_out=1; no generation until start.
REQ-040 Force count to 65535, complete one handshake -> count=0.
